// File: rtl/y_sram_update_writer.sv
// Read-modify-write of one complex element in a 256-bit Y SRAM word, with hold/done/err handshakes.
// Optional YWR_ACCUM_EN: saturating add into the lane instead of replacement.
module y_sram_update_writer #(
    parameter int unsigned NUM_ROWS      = 32,
    parameter int unsigned WORDS_PER_ROW = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         chg_valid,
    output logic         chg_ready,
    input  logic [15:0]  chg_row,
    input  logic [15:0]  chg_col,
    input  logic [23:0]  chg_real,
    input  logic [23:0]  chg_img,
    output logic [10:0]  rdAddr,
    input  logic [255:0] rdData,
    output logic         WE,
    output logic [10:0]  WriteAddress,
    output logic [255:0] WriteBus,
    output logic         hold,
    output logic         done,
    output logic         err,
    output logic [15:0]  upd_count
);

    localparam int unsigned AW       = 11;
    localparam int unsigned DW       = 256;
    localparam int unsigned EW       = 24;
    localparam int unsigned CW       = 16;
    localparam int unsigned NUM_COLS = 4 * WORDS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            chg_ready_q, chg_ready_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      lane_q, lane_d;
    logic [EW-1:0]   new_re_q, new_re_d;
    logic [EW-1:0]   new_im_q, new_im_d;
    logic            we_q, we_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_bus_q, wr_bus_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      re_lsb, im_lsb;

`ifdef YWR_ACCUM_EN
    // Signed add clamped to the 24-bit range on overflow.
    function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a, input logic [EW-1:0] b);
        logic [EW:0] s;
        s = {a[EW-1], a} + {b[EW-1], b};
        if (s[EW] != s[EW-1])
            return s[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
        return s[EW-1:0];
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        new_re_d  = new_re_q;
        new_im_d  = new_im_q;
        we_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_bus_d  = wr_bus_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        re_lsb    = {lane_q, 6'd24};
        im_lsb    = {lane_q, 6'd0};

        case (state_q)
            IDLE: begin
                if (chg_valid) begin
                    if (32'(chg_row) >= NUM_ROWS || 32'(chg_col) >= NUM_COLS) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = AW'(32'(chg_row) * WORDS_PER_ROW + 32'(chg_col >> 2));
                        rd_addr_d = addr_d;
                        lane_d    = chg_col[1:0];
                        new_re_d  = chg_real;
                        new_im_d  = chg_img;
                        state_d   = RD;
                    end
                end
            end
            RD: state_d = CAP;
            CAP: begin
                // Other lanes and all pad bits pass through from the read word.
                wr_bus_d = rdData;
`ifdef YWR_ACCUM_EN
                wr_bus_d[re_lsb +: EW] = sat_add(rdData[re_lsb +: EW], new_re_q);
                wr_bus_d[im_lsb +: EW] = sat_add(rdData[im_lsb +: EW], new_im_q);
`else
                wr_bus_d[re_lsb +: EW] = new_re_q;
                wr_bus_d[im_lsb +: EW] = new_im_q;
`endif
                state_d = WR;
            end
            WR: begin
                we_d      = 1'b1;
                wr_addr_d = addr_q;
                done_d    = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        chg_ready_d = (state_d == IDLE);
        hold_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            chg_ready_q <= 1'b1;
            rd_addr_q   <= '0;
            addr_q      <= '0;
            lane_q      <= '0;
            new_re_q    <= '0;
            new_im_q    <= '0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_bus_q    <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            chg_ready_q <= chg_ready_d;
            rd_addr_q   <= rd_addr_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            new_re_q    <= new_re_d;
            new_im_q    <= new_im_d;
            we_q        <= we_d;
            wr_addr_q   <= wr_addr_d;
            wr_bus_q    <= wr_bus_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign chg_ready    = chg_ready_q;
    assign rdAddr       = rd_addr_q;
    assign WE           = we_q;
    assign WriteAddress = wr_addr_q;
    assign WriteBus     = wr_bus_q;
    assign hold         = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign upd_count    = cnt_q;

endmodule

// File: doc/y_sram_update_writer.md
# y_sram_update_writer

Write-side companion to the Y-matrix datapath: accepts single-element admittance changes (row, col, real, imag), performs a read-modify-write of the affected 256-bit Y SRAM word, and drives the y_sram write port (WE, WriteAddress, WriteBus). It sits between the change-entry source and y_sram, alongside updateYcomputation, which only reads. While an update is in flight it raises `hold` so the computation side can be stalled.

## Interface
Parameters:
- NUM_ROWS, 32: valid Y rows; row ≥ NUM_ROWS is out of range.
- WORDS_PER_ROW, 16: SRAM words per Y row (4 elements per word → 64 columns).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- chg_valid  in  1  change entry present.
- chg_ready  out  1  block accepts entry this cycle.
- chg_row  in  16  Y row index.
- chg_col  in  16  Y column index.
- chg_real  in  24  signed real part.
- chg_img  in  24  signed imaginary part.
- rdAddr  out  11  y_sram read address (one read port dedicated to this block).
- rdData  in  256  y_sram read data, valid the cycle after rdAddr is presented.
- WE  out  1  y_sram write enable.
- WriteAddress  out  11  y_sram write address.
- WriteBus  out  256  y_sram write data.
- hold  out  1  high while not IDLE.
- done  out  1  one-cycle pulse per completed write.
- err  out  1  one-cycle pulse per rejected (out-of-range) entry.
- upd_count  out  16  successful writes since reset, wraps.

## Operation
- Word packing: element k (0..3) occupies bits [64k+63:64k]. Real is [64k+47:64k+24], imag is [64k+23:64k], and pad is [64k+63:64k+48]. The pad is preserved on write.
- Address: addr = chg_row*WORDS_PER_ROW + (chg_col>>2), truncated to 11 bits. Lane = chg_col[1:0].
- FSM states: IDLE, RD, CAP, WR.
  - IDLE: chg_ready=1. On chg_valid, latch the entry.
    - If out of range (row ≥ NUM_ROWS or col ≥ 4*WORDS_PER_ROW): pulse err next cycle, stay in IDLE, no SRAM access.
    - Otherwise go to RD.
  - RD: drive rdAddr = addr, go to CAP.
  - CAP: register rdData, merge the new element into the lane (see Configuration), go to WR.
  - WR: WE=1 for exactly one cycle with WriteAddress=addr and WriteBus=merged word. Pulse done, increment upd_count, return to IDLE.
- The other three lanes and all pad bits are written back unchanged.
- chg_ready=0 in RD/CAP/WR. chg_valid in those states is ignored; the source holds the entry.
- Reset values: chg_ready=1, WE=0, rdAddr=0, WriteAddress=0, WriteBus=0, hold=0, done=0, err=0, upd_count=0, state=IDLE.

## Timing
- Accept at edge N. The write occurs in cycle N+3 (WE high N+3..N+4). done is high in the same cycle as WE. Next accept is possible at N+4.
- Throughput: one update per 4 cycles. A rejected entry costs 1 cycle, and err is high the cycle after the accept.
- hold rises the cycle after accept and falls when returning to IDLE.
- Back-to-back updates to the same address are safe: the next RD issues after the write edge.
- Reset asserted mid-operation: WE drops asynchronously, the in-flight update is discarded (no partial write), and upd_count clears.
- upd_count wraps 0xFFFF → 0x0000.

## Configuration
- YWR_ACCUM_EN defined: lane value = old + new for real and imag independently. Both are 24-bit signed, saturating to 0x7FFFFF / 0x800000.
- YWR_ACCUM_EN undefined: lane real/imag are replaced by chg_real/chg_img.

## Test plan
- Replace (macro off): row=2, col=5, real=0x000123, img=0xFFFFFE, with rdData lane 1 = all-ones.
  - Required: WriteAddress=33, bits[111:88]=0x000123, bits[87:64]=0xFFFFFE, other lanes and pads unchanged, done at accept+3, upd_count=1.
- Accumulate (macro on): old real=0x7FFFF0 plus new 0x000020. Required: real=0x7FFFFF (saturated). Old img=0x800005 plus new 0xFFFFF0. Required: img=0x800000.
- Out of range: row=32, col=0. Required: err pulse next cycle, WE never asserted, upd_count unchanged, chg_ready high again after 1 cycle.
- Back-to-back: two valid entries to the same address (adds of +1 with macro on). Required: second write reflects the first, accepts 4 cycles apart, final lane = old+2.
- Reset in CAP: reset pulse low. Required: WE stays 0, no write occurs, all outputs at reset values, the next entry completes normally.
- Wrap: preload 0xFFFF updates (or force the counter). Required: the next done sets upd_count=0x0000.
